// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: read-only input ports, write strobed output registers,
// and an edge-triggered, maskable interrupt aggregator on a simple CPU bus.
module mmio_io_hub #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter logic [31:0] STRIDE    = 32'h0004_0000,
    parameter int unsigned N_IN      = 4,
    parameter int unsigned N_OUT     = 4,
    parameter int unsigned N_IRQ     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           IOBUS_ADDR,
    input  logic [31:0]           IOBUS_OUT,
    input  logic                  IOBUS_WR,
    output logic [31:0]           IOBUS_IN,
    input  logic [N_IN*32-1:0]    IN_DATA,
    output logic [N_OUT*32-1:0]   OUT_DATA,
    output logic [N_OUT-1:0]      WR_STB,
    input  logic [N_IRQ-1:0]      IRQ_SRC,
    output logic                  INT
);

    localparam int unsigned PendSlot = N_IN + N_OUT;
    localparam int unsigned MaskSlot = N_IN + N_OUT + 1;

    function automatic logic [31:0] slot_addr(input int unsigned s);
        return BASE_ADDR + STRIDE * s;
    endfunction

    logic [N_OUT-1:0][31:0] out_q, out_d;
    logic [N_OUT-1:0]       stb_q, wr_out;
    logic [N_IRQ-1:0]       pend_q, pend_d, pend_clr;
    logic [N_IRQ-1:0]       mask_q, mask_d;
    logic [N_IRQ-1:0]       prev_q;
    logic                   int_q;

    assign OUT_DATA = out_q;
    assign WR_STB   = stb_q;
    assign INT      = int_q;

    // Zero-latency read mux; unmapped addresses read as zero.
    always_comb begin
        IOBUS_IN = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (IOBUS_ADDR == slot_addr(k)) IOBUS_IN = IN_DATA[32*k +: 32];
        end
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (IOBUS_ADDR == slot_addr(N_IN + k)) IOBUS_IN = out_q[k];
        end
        if (IOBUS_ADDR == slot_addr(PendSlot)) IOBUS_IN[N_IRQ-1:0] = pend_q;
        if (IOBUS_ADDR == slot_addr(MaskSlot)) IOBUS_IN[N_IRQ-1:0] = mask_q;
    end

    always_comb begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            wr_out[k] = IOBUS_WR && (IOBUS_ADDR == slot_addr(N_IN + k));
            out_d[k]  = wr_out[k] ? IOBUS_OUT : out_q[k];
        end
        pend_clr = (IOBUS_WR && (IOBUS_ADDR == slot_addr(PendSlot))) ?
                   IOBUS_OUT[N_IRQ-1:0] : '0;
        // A new edge wins over a simultaneous write-1-to-clear.
        pend_d   = (pend_q & ~pend_clr) | (IRQ_SRC & ~prev_q);
        mask_d   = (IOBUS_WR && (IOBUS_ADDR == slot_addr(MaskSlot))) ?
                   IOBUS_OUT[N_IRQ-1:0] : mask_q;
    end

    // prev resets high so sources already asserted at release are not seen as edges.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q  <= '0;
            stb_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            prev_q <= '1;
            int_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            stb_q  <= wr_out;
            pend_q <= pend_d;
            mask_q <= mask_d;
            prev_q <= IRQ_SRC;
            int_q  <= |(pend_q & mask_q);
        end
    end

endmodule

// File: doc/mmio_io_hub.md
MMIO_IO_HUB -- requirements
Module: mmio_io_hub

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h11000000, address of slot 0.
REQ-002 SHALL have parameter STRIDE, default 32'h00040000, address step between consecutive slots.
REQ-003 SHALL have parameter N_IN, default 4, number of 32-bit read-only input ports (1..8).
REQ-004 SHALL have parameter N_OUT, default 4, number of 32-bit read/write output registers (1..8).
REQ-005 SHALL have parameter N_IRQ, default 4, number of interrupt sources (1..16).
REQ-006 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous reset, active-high.
REQ-008 SHALL have port IOBUS_ADDR  input  32  CPU bus address.
REQ-009 SHALL have port IOBUS_OUT  input  32  CPU write data.
REQ-010 SHALL have port IOBUS_WR  input  1  CPU write enable, sampled on CLK.
REQ-011 SHALL have port IOBUS_IN  output  32  read data to CPU.
REQ-012 SHALL have port IN_DATA  input  N_IN*32  input ports; port k at bits [32k+31:32k].
REQ-013 SHALL have port OUT_DATA  output  N_OUT*32  output registers; register k at bits [32k+31:32k].
REQ-014 SHALL have port WR_STB  output  N_OUT  one-cycle write strobe per output register.
REQ-015 SHALL have port IRQ_SRC  input  N_IRQ  interrupt sources, synchronous to CLK.
REQ-016 SHALL have port INT  output  1  aggregated interrupt request to CPU.

Function
REQ-017 SHALL decode slot s at address BASE_ADDR + s*STRIDE; exact 32-bit match only, no partial decode.
REQ-018 SHALL map slots 0..N_IN-1 to IN_DATA ports, N_IN..N_IN+N_OUT-1 to output registers, N_IN+N_OUT to IRQ_PEND, N_IN+N_OUT+1 to IRQ_MASK.
REQ-019 SHALL drive IOBUS_IN combinationally (zero-latency) from the addressed slot: input port value, output register value, or pending/mask zero-extended to 32 bits.
REQ-020 SHALL return 32'h0 on IOBUS_IN for any unmapped address.
REQ-021 SHALL, on a clock edge with IOBUS_WR=1 to output slot k, load IOBUS_OUT into register k; value visible on OUT_DATA the following cycle.
REQ-022 SHALL assert WR_STB[k] for exactly the one cycle in which the newly written value first appears on OUT_DATA; back-to-back writes give back-to-back strobes.
REQ-023 SHALL ignore writes to input-port slots and unmapped addresses (no state change, no strobe).
REQ-024 SHALL register IRQ_SRC each cycle (prev) and set pending[j] on a cycle where IRQ_SRC[j]=1 and prev[j]=0 (rising edge).
REQ-025 SHALL clear pending[j] on a write to IRQ_PEND with IOBUS_OUT[j]=1 (write-1-to-clear); zero bits leave pending unchanged.
REQ-026 SHALL give set priority: an edge on j in the same cycle as a clear of j leaves pending[j]=1.
REQ-027 SHALL load IRQ_MASK[N_IRQ-1:0] from IOBUS_OUT on write; upper bits ignored.
REQ-028 SHALL drive INT as a registered |(pending & mask), one cycle after pending/mask update.
REQ-029 SHALL keep pending bits latched regardless of mask; unmasking a pending source raises INT one cycle later.
REQ-030 SHALL treat a level held high as a single edge; no re-trigger until the source drops and rises again.

Reset
REQ-031 SHALL, while RST=1, immediately force OUT_DATA=0, WR_STB=0, pending=0, mask=0, INT=0.
REQ-032 SHALL reset prev to all ones so a source already high at reset release does not set pending.
REQ-033 SHALL abandon any write coincident with RST; no strobe after reset deasserts.

Verification
REQ-034 SHALL verify write 32'hA5A5_0001 to BASE+4*STRIDE (N_IN=4) -> OUT_DATA[31:0]=32'hA5A50001 and WR_STB=4'b0001 for one cycle, next cycle.
REQ-035 SHALL verify IN_DATA port 2 = 32'h0000_BEEF, IOBUS_ADDR=BASE+2*STRIDE -> IOBUS_IN=32'h0000BEEF same cycle; address BASE+3 -> 32'h0.
REQ-036 SHALL verify mask=4'b0010, IRQ_SRC[1] 0->1 -> pending=4'b0010, INT=1 one cycle after pending; write 1 to pending bit 1 -> INT=0.
REQ-037 SHALL verify IRQ_SRC[0] rising edge in the same cycle as a W1C of bit 0 -> pending[0] stays 1.
REQ-038 SHALL verify IRQ_SRC=4'b1111 held through reset release -> pending stays 4'b0000.
REQ-039 SHALL verify RST asserted mid-operation with OUT_DATA nonzero and INT=1 -> all outputs 0 without waiting for a CLK edge.
